// File: rtl/clk_mux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// clk_mux_sel_ctrl
// Select controller for a glitch-free two-input clock mux. Runs on the
// primary clock, synchronises the asynchronous switch request, qualifies
// the alternate clock by counting its rising edges per measurement window,
// and holds sel frozen for a dwell period after every change.
//
// Optional feature macro: CLK_MUX_FALLBACK_EN
//   defined   : loss of the alternate clock while selected forces a return
//               to the primary clock, and reselection waits for the request
//               to be withdrawn first.
//   undefined : loss of the alternate clock only raises the sticky fault.
// ---------------------------------------------------------------------------
module clk_mux_sel_ctrl #(
   parameter int SYNC_STAGES   = 2,
   parameter int DWELL_CYCLES  = 16,
   parameter int WINDOW_CYCLES = 64,
   parameter int MIN_EDGES     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req_sel,
   input  logic alt_clk,
   output logic sel,
   output logic busy,
   output logic alt_ok,
   output logic fault
);

   localparam int WIN_W   = $clog2(WINDOW_CYCLES + 1);
   localparam int EDGE_W  = $clog2(MIN_EDGES + 1);
   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
   localparam logic [EDGE_W-1:0]  EDGE_MAX   = EDGE_W'(MIN_EDGES);
   localparam logic [EDGE_W-1:0]  EDGE_PRE   = EDGE_W'(MIN_EDGES - 1);
   localparam logic [EDGE_W-1:0]  EDGE_ONE   = EDGE_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

   typedef enum logic [1:0] {
      ST_SEL0  = 2'd0,
      ST_SEL1  = 2'd1,
      ST_DWELL = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_req_sync;
   logic [SYNC_STAGES-1:0] r_alt_sync;
   logic                   r_alt_d;
   logic                   w_req_s;
   logic                   w_alt_s;
   logic                   w_alt_rise;

   // Shift both asynchronous inputs through their synchroniser chains
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_sync <= '0;
         r_alt_sync <= '0;
         r_alt_d    <= 1'b0;
      end else begin
         r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_sel};
         r_alt_sync <= {r_alt_sync[SYNC_STAGES-2:0], alt_clk};
         r_alt_d    <= w_alt_s;
      end
   end

   assign w_req_s    = r_req_sync[SYNC_STAGES-1];
   assign w_alt_s    = r_alt_sync[SYNC_STAGES-1];
   assign w_alt_rise = w_alt_s & ~r_alt_d;

   // ------------------------------------------------------------------
   // Alternate clock activity monitor
   // ------------------------------------------------------------------
   logic [WIN_W-1:0]  r_win_cnt;
   logic [EDGE_W-1:0] r_edge_cnt;
   logic              r_alt_ok;
   logic              w_win_end;
   logic              w_edge_sat;
   logic              w_enough;

   assign w_win_end  = (r_win_cnt == WIN_LAST);
   assign w_edge_sat = (r_edge_cnt == EDGE_MAX);
   // The edge arriving in the window's final cycle still counts toward it.
   assign w_enough   = w_edge_sat | (w_alt_rise & (r_edge_cnt == EDGE_PRE));

   // Count window cycles and saturating alt edges; publish verdict at window end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_alt_ok   <= 1'b0;
      end else if (w_win_end) begin
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_alt_ok   <= w_enough;
      end else begin
         r_win_cnt <= r_win_cnt + WIN_ONE;
         if (w_alt_rise && !w_edge_sat) begin
            r_edge_cnt <= r_edge_cnt + EDGE_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Selection state machine
   // ------------------------------------------------------------------
   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_sel;
   logic               w_sel_nxt;
   logic               r_fault;
   logic               w_fault_nxt;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [DWELL_W-1:0] w_dwell_nxt;
   logic               w_resel_ok;

`ifdef CLK_MUX_FALLBACK_EN
   // After a forced fallback the fault flag stays set until the request is
   // withdrawn in SEL0, so it doubles as the reselection lockout.
   assign w_resel_ok = ~r_fault;
`else
   assign w_resel_ok = 1'b1;
`endif

   // State, sel, fault and dwell counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_SEL0;
         r_sel       <= 1'b0;
         r_fault     <= 1'b0;
         r_dwell_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_fault     <= w_fault_nxt;
         r_dwell_cnt <= w_dwell_nxt;
      end
   end

   // Next-state decisions; alt_ok is the registered value, so a window-end
   // update in the same cycle is seen only on the following cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_fault_nxt = r_fault;
      w_dwell_nxt = '0;

      case (r_state)
         ST_SEL0: begin
            if (!w_req_s) begin
               w_fault_nxt = 1'b0;
            end else if (r_alt_ok && w_resel_ok) begin
               w_sel_nxt   = 1'b1;
               w_state_nxt = ST_DWELL;
            end
         end

         ST_SEL1: begin
            // A withdrawn request wins over a simultaneous alt_ok drop,
            // so a normal deselect never flags a fault.
            if (!w_req_s) begin
               w_sel_nxt   = 1'b0;
               w_state_nxt = ST_DWELL;
            end else if (!r_alt_ok) begin
               w_fault_nxt = 1'b1;
`ifdef CLK_MUX_FALLBACK_EN
               w_sel_nxt   = 1'b0;
               w_state_nxt = ST_DWELL;
`endif
            end
         end

         ST_DWELL: begin
            if (r_dwell_cnt == DWELL_LAST) begin
               w_state_nxt = r_sel ? ST_SEL1 : ST_SEL0;
            end else begin
               w_dwell_nxt = r_dwell_cnt + DWELL_ONE;
            end
         end

         default: begin
            // Unreachable encoding: park in DWELL so sel cannot change
            // before a full dwell period has elapsed.
            w_state_nxt = ST_DWELL;
         end
      endcase
   end

   assign sel    = r_sel;
   assign busy   = (r_state == ST_DWELL);
   assign alt_ok = r_alt_ok;
   assign fault  = r_fault;

endmodule

// File: tb/tb_clk_mux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_mux_sel_ctrl
// Directed scenarios with hand-computed expectations. Stimulus pushes
// {cycle, outputs} entries into a queue; a monitor on the falling edge pops
// every entry due in the current cycle and compares the outputs.
// Cycle 0 of each scenario is the first cycle after reset is released.
// Output vector order: {sel, busy, alt_ok, fault}.
// ---------------------------------------------------------------------------
module tb_clk_mux_sel_ctrl;

   logic clk;
   logic reset;
   logic req_sel;
   logic alt_clk;
   logic sel;
   logic busy;
   logic alt_ok;
   logic fault;

   logic alt_run;
   int   tcyc     = 0;
   int   base     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   typedef struct {
      int         cyc;
      logic [3:0] v;
      string      name;
   } exp_t;

   exp_t q[$];

   clk_mux_sel_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .req_sel (req_sel),
      .alt_clk (alt_clk),
      .sel     (sel),
      .busy    (busy),
      .alt_ok  (alt_ok),
      .fault   (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) tcyc <= tcyc + 1;

   // Alternate clock: period of 8 primary cycles, stoppable
   initial begin
      alt_clk = 1'b0;
      forever begin
         repeat (4) @(posedge clk);
         #3;
         if (alt_run) alt_clk = ~alt_clk;
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= tcyc) begin
         e = q.pop_front();
         n_checks++;
         if (e.cyc != tcyc || {sel, busy, alt_ok, fault} !== e.v) begin
            n_fail++;
            $display("FAIL %s: at cycle %0d (due %0d) sel/busy/alt_ok/fault got %b required %b",
                     e.name, tcyc - base, e.cyc - base, {sel, busy, alt_ok, fault}, e.v);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_at(input int rel, input logic [3:0] v, input string name);
      exp_t e;
      e.cyc  = base + rel;
      e.v    = v;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic wait_to(input int rel);
      while (tcyc < base + rel) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      base  = tcyc;
   endtask

   initial begin
      reset   = 1'b1;
      req_sel = 1'b0;
      alt_run = 1'b1;

      // Idle: request held low, alt_ok qualifies after the first window
      do_reset(3);
      expect_at(0,   4'b0000, "idle_reset");
      expect_at(63,  4'b0000, "idle_pre_window");
      expect_at(64,  4'b0010, "idle_alt_ok");
      expect_at(200, 4'b0010, "idle_200");
      wait_to(202);

      // Request at cycle 100: sel at 103, busy for 103..118
      req_sel = 1'b0;
      do_reset(2);
      expect_at(102, 4'b0010, "req_latency_pre");
      expect_at(103, 4'b1110, "req_sel_rise");
      expect_at(118, 4'b1110, "req_dwell_last");
      expect_at(119, 4'b1010, "req_dwell_done");
      expect_at(150, 4'b1010, "req_hold");
      wait_to(100);
      req_sel = 1'b1;
      wait_to(152);

      // Early request at 30: waits for alt_ok at 64, sel at 65
      req_sel = 1'b0;
      do_reset(2);
      expect_at(63, 4'b0000, "early_wait");
      expect_at(64, 4'b0010, "early_old_alt_ok");
      expect_at(65, 4'b1110, "early_sel");
      expect_at(80, 4'b1110, "early_dwell_last");
      expect_at(81, 4'b1010, "early_sel1");
      wait_to(30);
      req_sel = 1'b1;
      wait_to(83);

      // Request withdrawn during dwell: sel falls only at 120
      req_sel = 1'b0;
      do_reset(2);
      expect_at(103, 4'b1110, "drop_sel_rise");
      expect_at(119, 4'b1010, "drop_frozen");
      expect_at(120, 4'b0110, "drop_sel_fall");
      expect_at(135, 4'b0110, "drop_dwell_last");
      expect_at(136, 4'b0010, "drop_sel0");
      wait_to(100);
      req_sel = 1'b1;
      wait_to(105);
      req_sel = 1'b0;
      wait_to(138);

      // Alternate clock loss while selected
      req_sel = 1'b0;
      do_reset(2);
      expect_at(81,  4'b1010, "loss_sel1");
      expect_at(191, 4'b1010, "loss_last_good");
      expect_at(192, 4'b1000, "loss_alt_ok_fall");
`ifdef CLK_MUX_FALLBACK_EN
      expect_at(193, 4'b0101, "loss_fallback");
      expect_at(260, 4'b0011, "loss_blocked");
      expect_at(272, 4'b0011, "loss_fault_held");
      expect_at(273, 4'b0010, "loss_fault_clear");
      expect_at(283, 4'b1110, "loss_reselect");
`else
      expect_at(193, 4'b1001, "loss_fault_only");
      expect_at(260, 4'b1011, "loss_fault_sticky");
      expect_at(273, 4'b0111, "loss_deselect");
      expect_at(288, 4'b0111, "loss_dwell_last");
      expect_at(289, 4'b0011, "loss_sel0_fault");
      expect_at(290, 4'b0010, "loss_fault_clear");
`endif
      wait_to(30);
      req_sel = 1'b1;
      wait_to(130);
      alt_run = 1'b0;
      alt_clk = 1'b0;
      wait_to(200);
      alt_run = 1'b1;
      wait_to(270);
      req_sel = 1'b0;
`ifdef CLK_MUX_FALLBACK_EN
      wait_to(280);
      req_sel = 1'b1;
`endif
      wait_to(292);

      // Reset pulse during dwell, then requalification with request still high
      req_sel = 1'b0;
      do_reset(2);
      expect_at(65, 4'b1110, "rst_pre_sel");
      expect_at(70, 4'b1110, "rst_pre_dwell");
      wait_to(30);
      req_sel = 1'b1;
      wait_to(70);
      do_reset(1);
      expect_at(0,  4'b0000, "rst_all_zero");
      expect_at(63, 4'b0000, "rst_unqualified");
      expect_at(64, 4'b0010, "rst_requalified");
      expect_at(65, 4'b1110, "rst_reselect");
      wait_to(68);

      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
